ad5302_rx_module: RTL and testbench
===================================

AD5302_RX_MODULE -- requirements
Module: ad5302_rx_module

Interface
REQ-001 Parameter ADDRESS_DAC0, default 16'hdac0, SHALL be the tag placed in rx_data[31:16] for frames received on DSYNC0_N.
REQ-002 Parameter ADDRESS_DAC1, default 16'hdac1, SHALL be the tag placed in rx_data[31:16] for frames received on DSYNC1_N.
REQ-003 clk  input  1  system clock; SHALL be at least 4x the DCLK frequency.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 DSYNC0_N  input  1  frame select, DAC chip 0, active-low, asynchronous to clk.
REQ-006 DSYNC1_N  input  1  frame select, DAC chip 1, active-low, asynchronous to clk.
REQ-007 DCLK  input  1  serial clock, idle low (CPOL=0); data captured on falling edge (CPHA=1).
REQ-008 DIN  input  1  serial data, MSB first.
REQ-009 DLDAC_N  input  1  load-DAC strobe, active-low, asynchronous.
REQ-010 rx_data  output  32  {tag, 16-bit frame}, held stable while rx_vld=1.
REQ-011 rx_vld  output  1  received word available.
REQ-012 rx_rdy  input  1  consumer accepts rx_data when rx_vld&&rx_rdy.
REQ-013 rx_ovf  output  1  one-cycle pulse: unconsumed word overwritten.
REQ-014 rx_err  output  1  one-cycle pulse: frame aborted or both selects low.
REQ-015 dac0_a, dac0_b, dac1_a, dac1_b  output  8 each  DAC register model (AD5302_RX_SHADOW_EN only).

Function
REQ-016 All asynchronous inputs SHALL pass a 2-flop synchronizer plus one edge-detect flop before use.
REQ-017 FSM states: S_IDLE, S_SHIFT, S_CHECK, S_DONE.
REQ-018 S_IDLE -> S_SHIFT on synchronized falling edge of exactly one DSYNCx_N; selected channel latched; bit counter cleared.
REQ-019 Falling edge of both selects in the same cycle, or the second select falling during S_SHIFT: rx_err pulse, return to S_IDLE, no word produced.
REQ-020 S_SHIFT: each synchronized DCLK falling edge shifts DIN into bit 0 of a 16-bit register, counter +1.
REQ-021 Counter reaches 16 -> S_CHECK; DCLK edges after the 16th, until the select rises, SHALL be ignored.
REQ-022 Selected DSYNCx_N rising before 16 bits: rx_err pulse, shift register discarded, S_IDLE.
REQ-023 S_CHECK -> S_DONE in one cycle; S_DONE loads rx_data, sets rx_vld, then waits for the select high before S_IDLE.
REQ-024 Latency: rx_vld SHALL assert on the 4th clk rising edge after the 16th DCLK falling edge is first sampled by the synchronizer.
REQ-025 rx_vld SHALL stay high until rx_vld&&rx_rdy, clearing on the following edge.
REQ-026 A new word completing while rx_vld=1 and rx_rdy=0 SHALL overwrite rx_data and pulse rx_ovf; rx_vld stays high.
REQ-027 Acceptance and new-word completion in the same cycle SHALL load the new word, keep rx_vld=1, no rx_ovf.

Reset
REQ-028 rst_n low SHALL force S_IDLE, rx_data=0, rx_vld=0, rx_ovf=0, rx_err=0, counter=0, synchronizer flops to idle levels (selects/LDAC 1, DCLK 0), dac*_* = 0.
REQ-029 Reset mid-frame SHALL discard partial data; after release, the block SHALL wait for the next select falling edge and not resync into the frame in progress.

Configuration
REQ-030 With AD5302_RX_SHADOW_EN defined: a completed frame writes bits [11:4] into the input register of the selected chip, channel B if bit 15=1 else A; a synchronized DLDAC_N falling edge copies all four input registers to dac*_* simultaneously.
REQ-031 Frame completion and DLDAC_N edge in the same cycle: the copy SHALL take the newly written value.
REQ-032 Without AD5302_RX_SHADOW_EN: no shadow registers, dac*_* ports absent, DLDAC_N unused.

Structure
REQ-033 Package ad5302_pkg SHALL hold FSM state encoding, ADDRESS_DAC0/ADDRESS_DAC1 defaults, frame field positions (A/B bit 15, BUF 14, PD 13:12, data 11:4).
REQ-034 Sub-module spi_slave_sync SHALL implement the synchronizer and edge detection for one input, instanced per async input.

Verification
REQ-035 DSYNC0_N frame 16'h8A50, DCLK = clk/10 -> rx_data=32'hdac0_8A50, rx_vld within 4 clk of 16th edge.
REQ-036 DSYNC1_N frame of 9 bits then select high -> rx_err one pulse, rx_vld stays 0.
REQ-037 rx_rdy=0, two DSYNC0_N frames 16'h0010, 16'h0020 -> rx_ovf one pulse, rx_data=32'hdac0_0020.
REQ-038 SHADOW_EN: chip 0 A=8'h12, B=8'h34, then DLDAC_N low -> dac0_a=8'h12, dac0_b=8'h34 only after the strobe.
REQ-039 rst_n pulsed after bit 8 of a frame -> all outputs 0, no rx_vld for that frame; next full frame received correctly.

Source files
------------

// File: rtl/ad5302_pkg.sv
// Shared definitions for the AD5302 serial-interface receiver: FSM state
// encoding, default address tags and the layout of a 16-bit DAC frame.
package ad5302_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] ADDRESS_DAC0_DEF = 16'hdac0;
  localparam logic [15:0] ADDRESS_DAC1_DEF = 16'hdac1;

  // AD5302 input shift register layout, MSB first on the wire
  typedef struct packed {
    logic       ab;      // 15: 1 = channel B, 0 = channel A
    logic       bufsel;  // 14: reference buffer control
    logic [1:0] pd;      // 13:12: power-down mode
    logic [7:0] data;    // 11:4: DAC code
    logic [3:0] rsvd;    // 3:0: don't care
  } frame_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer plus one edge-detect flop for a single asynchronous
// input. IDLE sets the level the flops take in reset so that no edge is
// reported while the pipeline drains after reset.
module spi_slave_sync #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic lvl_o,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Metastability pair followed by a one-cycle history flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= IDLE;
      sync_q <= IDLE;
      prev_q <= IDLE;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign lvl_o  = sync_q;
  assign fall_o = prev_q & ~sync_q;
  assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/ad5302_rx_module.sv
// AD5302 serial-interface receiver: captures 16-bit frames addressed to one of
// two DAC chips and presents them as {tag, frame} on a valid/ready port.
// Optional macro AD5302_RX_SHADOW_EN adds a model of the DAC input and output
// registers, updated by frame writes and the DLDAC_N strobe.
module ad5302_rx_module
  import ad5302_pkg::*;
#(
  parameter logic [15:0] ADDRESS_DAC0 = ADDRESS_DAC0_DEF,
  parameter logic [15:0] ADDRESS_DAC1 = ADDRESS_DAC1_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DSYNC0_N,
  input  logic        DSYNC1_N,
  input  logic        DCLK,
  input  logic        DIN,
  input  logic        DLDAC_N,
  output logic [31:0] rx_data,
  output logic        rx_vld,
  input  logic        rx_rdy,
  output logic        rx_ovf,
  output logic        rx_err
`ifdef AD5302_RX_SHADOW_EN
  ,
  output logic [7:0]  dac0_a,
  output logic [7:0]  dac0_b,
  output logic [7:0]  dac1_a,
  output logic [7:0]  dac1_b
`endif
);

  logic s0_lvl, s0_fall, s0_rise;
  logic s1_lvl, s1_fall, s1_rise;
  logic dclk_fall, din_lvl;
  logic unused_dclk_lvl, unused_dclk_rise, unused_din_fall, unused_din_rise;

  spi_slave_sync #(.IDLE(1'b1)) u_sync_s0 (
    .clk(clk), .rst_n(rst_n), .async_i(DSYNC0_N),
    .lvl_o(s0_lvl), .fall_o(s0_fall), .rise_o(s0_rise));
  spi_slave_sync #(.IDLE(1'b1)) u_sync_s1 (
    .clk(clk), .rst_n(rst_n), .async_i(DSYNC1_N),
    .lvl_o(s1_lvl), .fall_o(s1_fall), .rise_o(s1_rise));
  spi_slave_sync #(.IDLE(1'b0)) u_sync_dclk (
    .clk(clk), .rst_n(rst_n), .async_i(DCLK),
    .lvl_o(unused_dclk_lvl), .fall_o(dclk_fall), .rise_o(unused_dclk_rise));
  spi_slave_sync #(.IDLE(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .async_i(DIN),
    .lvl_o(din_lvl), .fall_o(unused_din_fall), .rise_o(unused_din_rise));

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] sr_q;
  logic        chan_q;
  logic        err_q;
  logic        load_q;
  logic [1:0]  flush_q;
  logic [1:0]  armed_q;
  logic [31:0] rx_data_q;
  logic        rx_vld_q;
  logic        rx_ovf_q;

  logic        start0, start1, sel_lvl, sel_rise, oth_fall;
  frame_t      frame_w;
  logic [31:0] word_w;

  assign start0   = s0_fall & armed_q[0];
  assign start1   = s1_fall & armed_q[1];
  assign sel_lvl  = chan_q ? s1_lvl  : s0_lvl;
  assign sel_rise = chan_q ? s1_rise : s0_rise;
  assign oth_fall = chan_q ? s0_fall : s1_fall;
  assign frame_w  = sr_q;
  assign word_w   = {(chan_q ? ADDRESS_DAC1 : ADDRESS_DAC0), frame_w};

  // A select must be seen high after reset (once the synchronizers have
  // drained) before its falling edge may open a frame, so a frame already in
  // progress at reset release is never joined halfway through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= 2'd0;
      armed_q <= 2'b00;
    end else begin
      if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
      else                 armed_q <= armed_q | {s1_lvl, s0_lvl};
    end
  end

  // Frame FSM: select detection, bit shifting, abort handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      sr_q    <= 16'd0;
      chan_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start0 && start1) begin
            err_q <= 1'b1;
          end else if (start0 || start1) begin
            // the other select must be idle high, otherwise both are low
            if (start0 ? s1_lvl : s0_lvl) begin
              state_q <= S_SHIFT;
              chan_q  <= start1;
              cnt_q   <= 5'd0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (oth_fall || sel_rise) begin
            err_q   <= 1'b1;
            sr_q    <= 16'd0;
            state_q <= S_IDLE;
          end else if (dclk_fall) begin
            sr_q  <= {sr_q[14:0], din_lvl};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd15) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          state_q <= S_DONE;
          load_q  <= 1'b1;
        end
        S_DONE: begin
          if (sel_lvl) state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output word register with valid/ready handshake and overwrite flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q <= 32'd0;
      rx_vld_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      rx_ovf_q <= 1'b0;
      if (load_q) begin
        rx_data_q <= word_w;
        rx_vld_q  <= 1'b1;
        rx_ovf_q  <= rx_vld_q & ~rx_rdy;
      end else if (rx_vld_q && rx_rdy) begin
        rx_vld_q <= 1'b0;
      end
    end
  end

  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign rx_ovf  = rx_ovf_q;
  assign rx_err  = err_q;

`ifdef AD5302_RX_SHADOW_EN
  logic ld_fall, unused_ld_lvl, unused_ld_rise;
  logic [7:0] in0a_q, in0b_q, in1a_q, in1b_q;
  logic [7:0] in0a_d, in0b_d, in1a_d, in1b_d;
  logic [7:0] dac0a_q, dac0b_q, dac1a_q, dac1b_q;

  spi_slave_sync #(.IDLE(1'b1)) u_sync_ldac (
    .clk(clk), .rst_n(rst_n), .async_i(DLDAC_N),
    .lvl_o(unused_ld_lvl), .fall_o(ld_fall), .rise_o(unused_ld_rise));

  // Next input-register contents; a completed frame writes one channel
  always_comb begin
    in0a_d = in0a_q;
    in0b_d = in0b_q;
    in1a_d = in1a_q;
    in1b_d = in1b_q;
    if (load_q) begin
      case ({chan_q, frame_w.ab})
        2'b00:   in0a_d = frame_w.data;
        2'b01:   in0b_d = frame_w.data;
        2'b10:   in1a_d = frame_w.data;
        default: in1b_d = frame_w.data;
      endcase
    end
  end

  // Input registers, and the LDAC copy which sees a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in0a_q <= 8'd0; in0b_q <= 8'd0; in1a_q <= 8'd0; in1b_q <= 8'd0;
      dac0a_q <= 8'd0; dac0b_q <= 8'd0; dac1a_q <= 8'd0; dac1b_q <= 8'd0;
    end else begin
      in0a_q <= in0a_d; in0b_q <= in0b_d; in1a_q <= in1a_d; in1b_q <= in1b_d;
      if (ld_fall) begin
        dac0a_q <= in0a_d; dac0b_q <= in0b_d;
        dac1a_q <= in1a_d; dac1b_q <= in1b_d;
      end
    end
  end

  assign dac0_a = dac0a_q;
  assign dac0_b = dac0b_q;
  assign dac1_a = dac1a_q;
  assign dac1_b = dac1b_q;
`else
  logic unused_ldac;
  assign unused_ldac = DLDAC_N;
`endif

endmodule

// File: tb/tb_ad5302_rx_module.sv
// Randomized and directed bench for ad5302_rx_module. Frames are driven on the
// serial pins (DCLK = clk/10) and compared against a word-level model of the
// receiver kept here: expected {tag, frame}, valid/overwrite state, and error
// pulse counts.
module tb_ad5302_rx_module;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        DSYNC0_N = 1'b1;
  logic        DSYNC1_N = 1'b1;
  logic        DCLK = 1'b0;
  logic        DIN = 1'b0;
  logic        DLDAC_N = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [31:0] rx_data;
  logic        rx_vld, rx_ovf, rx_err;
`ifdef AD5302_RX_SHADOW_EN
  logic [7:0]  dac0_a, dac0_b, dac1_a, dac1_b;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  int          err_cnt = 0;
  logic [31:0] m_data = 32'd0;
  logic        m_vld = 1'b0;

  always #5 clk = ~clk;

  ad5302_rx_module dut (
    .clk(clk), .rst_n(rst_n),
    .DSYNC0_N(DSYNC0_N), .DSYNC1_N(DSYNC1_N),
    .DCLK(DCLK), .DIN(DIN), .DLDAC_N(DLDAC_N),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .rx_ovf(rx_ovf), .rx_err(rx_err)
`ifdef AD5302_RX_SHADOW_EN
    , .dac0_a(dac0_a), .dac0_b(dac0_b), .dac1_a(dac1_a), .dac1_b(dac1_b)
`endif
  );

  always @(negedge clk) if (rx_err) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic dclk_bit(input logic b);
    DCLK = 1'b1;
    DIN  = b;
    repeat (5) @(negedge clk);
    DCLK = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // One frame of nbits on the chosen select, then extra DCLK pulses, then the
  // select rises. A 16-bit frame has its latency and word checked exactly.
  task automatic send_frame(input bit ch, input int nbits, input int extra,
                            input logic [15:0] fr, input bit rdy);
    logic [31:0] exp_w;
    logic        exp_ovf;
    int          e0;
    e0 = err_cnt;
    rx_rdy = rdy;
    repeat (2) @(negedge clk);
    if (rdy) m_vld = 1'b0;
    if (ch) DSYNC1_N = 1'b0; else DSYNC0_N = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits + extra; i++) begin
      DCLK = 1'b1;
      DIN  = (i < 16) ? fr[15-i] : 1'($urandom_range(1));
      repeat (5) @(negedge clk);
      DCLK = 1'b0;
      if (i == 15) begin
        exp_w   = {(ch ? 16'hdac1 : 16'hdac0), fr};
        exp_ovf = m_vld && !rdy;
        repeat (4) @(negedge clk);
        if (!m_vld) chk("vld_early", {31'd0, rx_vld}, 32'd0);
        @(negedge clk);
        chk("vld_lat", {31'd0, rx_vld}, 32'd1);
        chk("data", rx_data, exp_w);
        chk("ovf", {31'd0, rx_ovf}, {31'd0, exp_ovf});
        m_vld  = !rdy;
        m_data = exp_w;
      end else begin
        repeat (5) @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
    DSYNC0_N = 1'b1;
    DSYNC1_N = 1'b1;
    repeat (6) @(negedge clk);
    chk(nbits >= 16 ? "no_err" : "abort_err", err_cnt - e0, (nbits >= 16) ? 0 : 1);
    chk("vld_hold", {31'd0, rx_vld}, {31'd0, m_vld});
    if (m_vld) chk("data_hold", rx_data, m_data);
    chk("ovf_idle", {31'd0, rx_ovf}, 32'd0);
  endtask

  task automatic accept();
    rx_rdy = 1'b1;
    @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
    m_vld = 1'b0;
    chk("accept", {31'd0, rx_vld}, 32'd0);
  endtask

  initial begin
    int e0;
    logic [15:0] partial;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 32'd0);
    chk("rst_vld", {31'd0, rx_vld}, 32'd0);
    chk("rst_flags", {30'd0, rx_ovf, rx_err}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // basic frame on DSYNC0_N
    send_frame(1'b0, 16, 0, 16'h8A50, 1'b0);
    accept();

    // short frame on DSYNC1_N aborts
    send_frame(1'b1, 9, 0, 16'hFFFF, 1'b0);

    // two unconsumed frames overwrite
    send_frame(1'b0, 16, 0, 16'h0010, 1'b0);
    send_frame(1'b0, 16, 0, 16'h0020, 1'b0);
    accept();

    // DCLK edges after the 16th are ignored
    send_frame(1'b1, 16, 3, 16'h1234, 1'b1);

    // both selects falling together
    e0 = err_cnt;
    DSYNC0_N = 1'b0;
    DSYNC1_N = 1'b0;
    repeat (6) @(negedge clk);
    chk("both_fall_err", err_cnt - e0, 1);
    DSYNC0_N = 1'b1;
    DSYNC1_N = 1'b1;
    repeat (6) @(negedge clk);
    chk("both_fall_vld", {31'd0, rx_vld}, 32'd0);

    // second select falling mid-frame
    e0 = err_cnt;
    DSYNC0_N = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) dclk_bit(1'b1);
    DSYNC1_N = 1'b0;
    repeat (6) @(negedge clk);
    chk("second_sel_err", err_cnt - e0, 1);
    DSYNC0_N = 1'b1;
    DSYNC1_N = 1'b1;
    repeat (6) @(negedge clk);
    chk("second_sel_vld", {31'd0, rx_vld}, 32'd0);

`ifdef AD5302_RX_SHADOW_EN
    send_frame(1'b0, 16, 0, 16'h0120, 1'b1);
    send_frame(1'b0, 16, 0, 16'h8340, 1'b1);
    chk("dac0_a_pre", {24'd0, dac0_a}, 32'h0);
    chk("dac0_b_pre", {24'd0, dac0_b}, 32'h0);
    DLDAC_N = 1'b0;
    repeat (6) @(negedge clk);
    chk("dac0_a", {24'd0, dac0_a}, 32'h12);
    chk("dac0_b", {24'd0, dac0_b}, 32'h34);
    chk("dac1_a", {24'd0, dac1_a}, 32'h0);
    DLDAC_N = 1'b1;
    repeat (4) @(negedge clk);
`endif

    // reset after bit 8 of a frame
    partial = 16'hC3A5;
    rx_rdy = 1'b0;
    e0 = err_cnt;
    DSYNC0_N = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) dclk_bit(partial[15-i]);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_data", rx_data, 32'd0);
    chk("midrst_flags", {29'd0, rx_vld, rx_ovf, rx_err}, 32'd0);
`ifdef AD5302_RX_SHADOW_EN
    chk("midrst_dac", {dac0_a, dac0_b, dac1_a, dac1_b}, 32'd0);
`endif
    rst_n = 1'b1;
    m_vld = 1'b0;
    m_data = 32'd0;
    for (int i = 8; i < 16; i++) dclk_bit(partial[15-i]);
    repeat (3) @(negedge clk);
    DSYNC0_N = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_vld", {31'd0, rx_vld}, 32'd0);
    chk("midrst_no_err", err_cnt - e0, 0);
    send_frame(1'b0, 16, 0, 16'h5AC3, 1'b0);
    accept();

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      bit          ch, rdy;
      logic [15:0] fr;
      int          nb;
      ch  = 1'($urandom_range(1));
      rdy = 1'($urandom_range(1));
      fr  = 16'($urandom);
      nb  = ($urandom_range(7) == 0) ? int'($urandom_range(15, 1)) : 16;
      send_frame(ch, nb, (nb == 16) ? int'($urandom_range(2)) : 0, fr, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
